// File: rtl/stream_out_fifo.sv
// Elastic first-word-fall-through output buffer feeding an AXI-Stream master port,
// with early up_ready back-pressure, packet accounting and sticky overflow detection.
module stream_out_fifo #(
  parameter int unsigned DW           = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_last,
  output logic                     up_ready,
  output logic                     m_valid,
  output logic [DW-1:0]            m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_done,
  output logic [15:0]              pkt_cnt,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 16;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t          mem_q [DEPTH];
  beat_t          wr_beat;
  beat_t          rd_beat;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           pkt_done_q, pkt_done_d;
  logic [PW-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic           full;
  logic           push;
  logic           pop;

  // Handshake decode; a pop frees a slot in the same cycle, so full+pop still accepts.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    pop     = m_valid & m_ready;
    push    = in_valid & (~full | pop);
    wr_beat = '{last: in_last, data: in_data};
    rd_beat = mem_q[rd_ptr_q];
  end

  // Next-state for pointers, occupancy, overflow and packet accounting.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    pkt_done_d = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    // Set has priority over clear so a simultaneous drop is never lost.
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (in_valid & full & ~pop) begin
      ovf_d = 1'b1;
    end

    if (pop & rd_beat.last) begin
      pkt_done_d = 1'b1;
      pkt_cnt_d  = pkt_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      pkt_done_q <= pkt_done_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // Storage contents need no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_beat;
    end
  end

  // Fall-through view of the head entry, decoded straight from the registers.
  always_comb begin
    m_valid  = (count_q != '0);
    m_data   = rd_beat.data;
    m_last   = rd_beat.last & m_valid;
    up_ready = (count_q <= CW'(DEPTH - AFULL_MARGIN));
    count    = count_q;
    pkt_done = pkt_done_q;
    pkt_cnt  = pkt_cnt_q;
    ovf      = ovf_q;
  end

endmodule

// File: tb/tb_stream_out_fifo.sv
// Scoreboard bench for stream_out_fifo: stimulus queues expected beats, a negedge
// monitor pops and compares every output transfer and checks AXI hold and pkt_done.
module tb_stream_out_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        up_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic [4:0]  count;
  logic        pkt_done;
  logic [15:0] pkt_cnt;
  logic        ovf;
  logic        clr_ovf;

  int          tests;
  int          fails;
  logic [32:0] sb [$];

  logic        hold;
  logic [32:0] hold_beat;
  logic        exp_done;

  stream_out_fifo #(.DW(32), .DEPTH(16), .AFULL_MARGIN(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .up_ready (up_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .count    (count),
    .pkt_done (pkt_done),
    .pkt_cnt  (pkt_cnt),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic expect_push);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    if (expect_push) sb.push_back({l, d});
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    m_ready = 1'b1;
    while (!(sb.size() == 0 && count == 5'd0) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got count %0d queue %0d expected 0 0", count, sb.size());
    end
  endtask

  // Monitor: compares every transfer, AXI stability, and the one-cycle pkt_done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold     = 1'b0;
      exp_done = 1'b0;
    end else begin
      check("pkt_done", 33'(pkt_done), 33'(exp_done));
      if (hold) begin
        check("hold_valid", 33'(m_valid), 33'(1));
        check("hold_beat", {m_last, m_data}, hold_beat);
      end
      exp_done = 1'b0;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected none", {m_last, m_data});
        end else begin
          check("beat", {m_last, m_data}, sb.pop_front());
        end
        exp_done = m_last;
      end
      hold      = m_valid && !m_ready;
      hold_beat = {m_last, m_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int cyc;
    tests    = 0;
    fails    = 0;
    hold     = 1'b0;
    exp_done = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    m_ready  = 1'b0;
    clr_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Reset state
    check("rst_m_valid", 33'(m_valid), 33'(0));
    check("rst_count", 33'(count), 33'(0));
    check("rst_up_ready", 33'(up_ready), 33'(1));
    check("rst_ovf", 33'(ovf), 33'(0));
    check("rst_pkt_cnt", 33'(pkt_cnt), 33'(0));

    // Packet of 8 with m_ready high; m_valid one cycle after first in_valid
    m_ready = 1'b1;
    beat(32'd0, 1'b0, 1'b1);
    check("latency_m_valid", 33'(m_valid), 33'(1));
    for (int i = 1; i < 8; i++) beat(32'(i), (i == 7), 1'b1);
    idle();
    wait_drain();
    step();
    check("t1_count", 33'(count), 33'(0));
    check("t1_pkt_cnt", 33'(pkt_cnt), 33'(1));
    repeat (3) step();
    check("empty_m_valid", 33'(m_valid), 33'(0));
    check("empty_count", 33'(count), 33'(0));

    // Fill to the almost-full threshold with the sink stalled
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) beat(32'h100 + 32'(i), 1'b0, 1'b1);
    idle();
    check("t2_count12", 33'(count), 33'(12));
    check("t2_up_ready12", 33'(up_ready), 33'(1));
    beat(32'h10c, 1'b1, 1'b1);
    idle();
    check("t2_count13", 33'(count), 33'(13));
    check("t2_up_ready13", 33'(up_ready), 33'(0));
    check("t2_ovf", 33'(ovf), 33'(0));
    m_ready = 1'b1;
    step();
    check("t2_count_after_pop", 33'(count), 33'(12));
    check("t2_up_ready_back", 33'(up_ready), 33'(1));
    wait_drain();
    step();
    check("t2_pkt_cnt", 33'(pkt_cnt), 33'(2));

    // Overflow: 17 beats into 16 entries, then set-wins and clear
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) beat(32'h300 + 32'(i), (i == 15), (i < 16));
    idle();
    check("t3_count", 33'(count), 33'(16));
    check("t3_ovf", 33'(ovf), 33'(1));
    check("t3_up_ready", 33'(up_ready), 33'(0));
    clr_ovf = 1'b1;
    beat(32'h3ee, 1'b0, 1'b0);
    idle();
    check("t3_set_wins", 33'(ovf), 33'(1));
    step();
    clr_ovf = 1'b0;
    check("t3_clr_ovf", 33'(ovf), 33'(0));
    check("t3_count_kept", 33'(count), 33'(16));

    // Full with simultaneous push and pop
    m_ready = 1'b1;
    beat(32'h3ff, 1'b1, 1'b1);
    idle();
    check("t4_count", 33'(count), 33'(16));
    check("t4_ovf", 33'(ovf), 33'(0));
    wait_drain();
    step();
    check("t4_pkt_cnt", 33'(pkt_cnt), 33'(4));

    // Random back-pressure, 4 packets of 25 beats across pointer wraps
    issued = 0;
    cyc    = 0;
    while (issued < 100 && cyc < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (up_ready) begin
        beat(32'h1000 + 32'(issued), ((issued % 25) == 24), 1'b1);
        issued++;
      end else begin
        idle();
        step();
      end
      cyc++;
    end
    idle();
    check("t5_issued", 33'(issued), 33'(100));
    wait_drain();
    step();
    check("t5_pkt_cnt", 33'(pkt_cnt), 33'(8));
    check("t5_ovf", 33'(ovf), 33'(0));

    // Asynchronous reset mid-packet
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(32'h500 + 32'(i), 1'b0, 1'b1);
    idle();
    check("t6_count6", 33'(count), 33'(6));
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("t6_m_valid", 33'(m_valid), 33'(0));
    check("t6_count", 33'(count), 33'(0));
    check("t6_up_ready", 33'(up_ready), 33'(1));
    check("t6_pkt_cnt", 33'(pkt_cnt), 33'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(32'h600 + 32'(i), (i == 4), 1'b1);
    idle();
    wait_drain();
    step();
    check("t6_fresh_pkt_cnt", 33'(pkt_cnt), 33'(1));
    check("t6_fresh_count", 33'(count), 33'(0));

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
